// File: rtl/replay_restore_if.sv
// Bus bundle for replay_restore: commit capture, replay address stream and restore outputs.
// The core/replay-controller side uses the master modport; replay_restore uses slave.
interface replay_restore_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  error_i;
    logic                  commit_we_i;
    logic [ADDR_WIDTH-1:0] commit_addr_i;
    logic [DATA_WIDTH-1:0] commit_data_i;
    logic                  replay_done_i;
    logic [ADDR_WIDTH-1:0] replay_addr_i;
    logic                  rf_we_o;
    logic [ADDR_WIDTH-1:0] rf_addr_o;
    logic [DATA_WIDTH-1:0] rf_data_o;
    logic                  core_stall_o;
    logic                  restore_done_o;
    logic                  restore_err_o;

    modport master (
        output error_i, commit_we_i, commit_addr_i, commit_data_i, replay_done_i, replay_addr_i,
        input  rf_we_o, rf_addr_o, rf_data_o, core_stall_o, restore_done_o, restore_err_o
    );

    modport slave (
        input  error_i, commit_we_i, commit_addr_i, commit_data_i, replay_done_i, replay_addr_i,
        output rf_we_o, rf_addr_o, rf_data_o, core_stall_o, restore_done_o, restore_err_o
    );
endinterface

// File: rtl/replay_restore.sv
// Shadow register file that captures committed writes and replays them into the core after an error.
// Optional REPLAY_RESTORE_PARITY_EN adds a per-entry even-parity bit and a sticky restore_err_o.
module replay_restore #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input logic             clk,
    input logic             rst_n,
    replay_restore_if.slave bus
);
    localparam int NUM_REG = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RESTORE = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t                             state_r;
    logic [NUM_REG-1:0][DATA_WIDTH-1:0] shadow_r;
    logic                               rf_we_r;
    logic [ADDR_WIDTH-1:0]              rf_addr_r;
    logic [DATA_WIDTH-1:0]              rf_data_r;
    logic                               restore_done_r;
    logic                               capture_s;
    logic                               sample_s;
    logic [DATA_WIDTH-1:0]              rd_data_s;

    // Capture only while idle; the first low replay_done cycle in ARMED already carries an address
    always_comb begin
        capture_s = 1'b0;
        sample_s  = 1'b0;
        rd_data_s = shadow_r[bus.replay_addr_i];
        if (state_r == IDLE) begin
            capture_s = bus.commit_we_i && !bus.error_i && (bus.commit_addr_i != ADDR_ZERO);
        end else begin
            sample_s = ((state_r == ARMED) || (state_r == RESTORE)) && !bus.replay_done_i;
        end
    end

    // Shadow capture; entry 0 is never written so it always reads back as zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= {(NUM_REG * DATA_WIDTH){1'b0}};
        end else if (capture_s) begin
            shadow_r[bus.commit_addr_i] <= bus.commit_data_i;
        end
    end

    // Restore sequencer with registered rf_* and done outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            rf_we_r        <= 1'b0;
            rf_addr_r      <= ADDR_ZERO;
            rf_data_r      <= DATA_ZERO;
            restore_done_r <= 1'b0;
        end else begin
            rf_we_r        <= 1'b0;
            restore_done_r <= 1'b0;
            if (sample_s) begin
                rf_we_r   <= (bus.replay_addr_i != ADDR_ZERO);
                rf_addr_r <= bus.replay_addr_i;
                rf_data_r <= rd_data_s;
            end
            case (state_r)
                IDLE: begin
                    if (bus.error_i) state_r <= ARMED;
                end
                ARMED: begin
                    if (!bus.replay_done_i) state_r <= RESTORE;
                end
                RESTORE: begin
                    if (bus.replay_done_i) begin
                        state_r        <= FINISH;
                        restore_done_r <= 1'b1;
                    end
                end
                FINISH: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.rf_we_o        = rf_we_r;
    assign bus.rf_addr_o      = rf_addr_r;
    assign bus.rf_data_o      = rf_data_r;
    assign bus.restore_done_o = restore_done_r;
    // Stall starts combinationally in the error cycle itself
    assign bus.core_stall_o   = bus.error_i || (state_r != IDLE);

`ifdef REPLAY_RESTORE_PARITY_EN
    logic [NUM_REG-1:0] parity_r;
    logic               restore_err_r;
    logic               par_bad_s;

    function automatic logic even_parity_f(input logic [DATA_WIDTH-1:0] data);
        return ^data;
    endfunction

    assign par_bad_s = sample_s && (bus.replay_addr_i != ADDR_ZERO)
                       && (parity_r[bus.replay_addr_i] != even_parity_f(rd_data_s));

    // Parity bit stored alongside each captured entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_r <= {NUM_REG{1'b0}};
        end else if (capture_s) begin
            parity_r[bus.commit_addr_i] <= even_parity_f(bus.commit_data_i);
        end
    end

    // Sticky integrity error, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            restore_err_r <= 1'b0;
        end else if (par_bad_s) begin
            restore_err_r <= 1'b1;
        end
    end

    assign bus.restore_err_o = restore_err_r;
`else
    assign bus.restore_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_replay_restore.sv
// Scoreboard bench for replay_restore: stimulus pushes expected restore writes, a negedge monitor pops them.
module tb_replay_restore;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;

    replay_restore_if bus ();

    replay_restore dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        int          cyc;
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [4:0]  sweep_q[$];
    logic [31:0] model[32];
    int          n_checks     = 0;
    int          n_pass       = 0;
    int          done_seen    = 0;
    int          done_exp     = 0;
    int          exp_done_cyc = -1;
    int          bad_addr     = -1;
    logic        err_model    = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare every observed restore write and done pulse against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.rf_we_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", bus.rf_we_o, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("write_cycle", cyc, e.cyc);
                    check("write_addr", bus.rf_addr_o, e.a);
                    check("write_data", bus.rf_data_o, e.d);
                end
            end
            if (bus.restore_done_o) begin
                done_seen++;
                check("done_cycle", cyc, exp_done_cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic [4:0] a, input logic [31:0] d);
        bus.commit_we_i   = 1'b1;
        bus.commit_addr_i = a;
        bus.commit_data_i = d;
        if (a != 5'd0) model[a] = d;
        tick();
        bus.commit_we_i = 1'b0;
    endtask

    // Raise error for one cycle, optionally with a commit that must be dropped
    task automatic raise_error(input logic cw, input logic [4:0] a, input logic [31:0] d);
        bus.error_i       = 1'b1;
        bus.commit_we_i   = cw;
        bus.commit_addr_i = a;
        bus.commit_data_i = d;
        #1;
        check("stall_in_error_cycle", bus.core_stall_o, 1'b1);
        tick();
        bus.error_i     = 1'b0;
        bus.commit_we_i = 1'b0;
    endtask

    task automatic do_sweep(input int err_at);
        for (int i = 0; i < sweep_q.size(); i++) begin
            bus.replay_done_i = 1'b0;
            bus.replay_addr_i = sweep_q[i];
            bus.error_i       = (i == err_at);
            if (sweep_q[i] != 5'd0) exp_q.push_back('{cyc + 1, sweep_q[i], model[sweep_q[i]]});
            if (int'(sweep_q[i]) == bad_addr) err_model = 1'b1;
            tick();
            check("rf_we", bus.rf_we_o, sweep_q[i] != 5'd0);
            check("restore_err", bus.restore_err_o, err_model);
            check("stall_restore", bus.core_stall_o, 1'b1);
        end
        bus.error_i = 1'b0;
    endtask

    task automatic do_finish();
        bus.replay_done_i = 1'b1;
        bus.replay_addr_i = 5'd0;
        exp_done_cyc = cyc + 1;
        done_exp++;
        tick();
        check("stall_in_finish", bus.core_stall_o, 1'b1);
        check("done_pulse", bus.restore_done_o, 1'b1);
        tick();
        check("stall_released", bus.core_stall_o, 1'b0);
        check("done_single", bus.restore_done_o, 1'b0);
        check("restore_err_after", bus.restore_err_o, err_model);
    endtask

    task automatic check_reset_values();
        check("rst_rf_we", bus.rf_we_o, 1'b0);
        check("rst_rf_addr", bus.rf_addr_o, 5'd0);
        check("rst_rf_data", bus.rf_data_o, 32'd0);
        check("rst_done", bus.restore_done_o, 1'b0);
        check("rst_err", bus.restore_err_o, 1'b0);
        check("rst_stall", bus.core_stall_o, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        bus.error_i       = 1'b0;
        bus.commit_we_i   = 1'b0;
        bus.commit_addr_i = 5'd0;
        bus.commit_data_i = 32'd0;
        bus.replay_done_i = 1'b1;
        bus.replay_addr_i = 5'd0;
        #2 rst_n = 1'b0;
        #1 check_reset_values();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        check_reset_values();

        // Full sweep after two commits
        commit(5'd3, 32'hDEADBEEF);
        commit(5'd7, 32'h12345678);
        raise_error(1'b0, 5'd0, 32'd0);
        sweep_q.delete();
        sweep_q.push_back(5'd0);
        for (int a = 1; a < 32; a++) sweep_q.push_back(5'(a));
        do_sweep(-1);
        do_finish();

        // Commit coinciding with the error cycle is dropped
        raise_error(1'b1, 5'd5, 32'hAAAA5555);
        sweep_q = '{5'd0, 5'd5, 5'd3};
        do_sweep(-1);
        do_finish();

        // Commit to address 0 is ignored and replaying it writes nothing
        commit(5'd0, 32'hFFFFFFFF);
        raise_error(1'b0, 5'd0, 32'd0);
        sweep_q = '{5'd0, 5'd0, 5'd7, 5'd0};
        do_sweep(-1);
        do_finish();

        // Second error mid-restore is absorbed; duplicates and reordering allowed
        commit(5'd12, 32'h0BADF00D);
        raise_error(1'b0, 5'd0, 32'd0);
        sweep_q = '{5'd0, 5'd12, 5'd3, 5'd12, 5'd7};
        do_sweep(2);
        do_finish();
        tick();
        check("no_rearm_stall", bus.core_stall_o, 1'b0);
        check("no_rearm_done", bus.restore_done_o, 1'b0);

        // Reset while address 12 is being restored
        raise_error(1'b0, 5'd0, 32'd0);
        sweep_q.delete();
        for (int a = 0; a < 12; a++) sweep_q.push_back(5'(a));
        do_sweep(-1);
        bus.replay_done_i = 1'b0;
        bus.replay_addr_i = 5'd12;
        tick();
        check("inflight_we", bus.rf_we_o, 1'b1);
        check("inflight_addr", bus.rf_addr_o, 5'd12);
        rst_n = 1'b0;
        #1;
        bus.replay_done_i = 1'b1;
        bus.replay_addr_i = 5'd0;
        check_reset_values();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        check("scoreboard_drained_at_reset", exp_q.size(), 0);
        raise_error(1'b0, 5'd0, 32'd0);
        sweep_q = '{5'd0, 5'd3};
        do_sweep(-1);
        do_finish();

        // Shadow integrity: corrupt entry 9 when parity is built in
        commit(5'd9, 32'h00000001);
        raise_error(1'b0, 5'd0, 32'd0);
`ifdef REPLAY_RESTORE_PARITY_EN
        force dut.parity_r[9] = 1'b0;
        bad_addr = 9;
`endif
        sweep_q = '{5'd0, 5'd8, 5'd9, 5'd10};
        do_sweep(-1);
        do_finish();
`ifdef REPLAY_RESTORE_PARITY_EN
        release dut.parity_r[9];
`endif
        tick();
        check("restore_err_sticky", bus.restore_err_o, err_model);

        tick();
        check("done_count", done_seen, done_exp);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
